// File: rtl/led4_capture.sv
// Capture side of a 4-digit multiplexed 7-segment bus: rebuilds digits 3..0 and publishes whole frames.
// Optional saturating error counter port enabled by defining LED4_CAPTURE_ERRCNT_EN.
module led4_capture #(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [7:0] LED,
  input  logic [3:0] selecters,
  output logic [7:0] LED3,
  output logic [7:0] LED2,
  output logic [7:0] LED1,
  output logic [7:0] LED0,
  output logic       frame_valid,
  output logic       sel_error,
  output logic       seq_error
`ifdef LED4_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXP2, EXP1, EXP0} state_t;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  logic [3:0] in_sel_q, in_sel_d;
  logic [7:0] in_led_q, in_led_d;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       changed, capture;

  state_t     state_q, state_d;
  logic [7:0] sh3_q, sh3_d, sh2_q, sh2_d, sh1_q, sh1_d;
  logic [7:0] out3_q, out3_d, out2_q, out2_d, out1_q, out1_d, out0_q, out0_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sel_error_q, sel_error_d;
  logic       seq_error_q, seq_error_d;

  logic       blank, legal;
  logic [1:0] digit, exp_digit;

  // A dwell is captured once, when the registered pair has been seen STABLE_CYCLES times.
  assign changed = (selecters != in_sel_q) || (LED != in_led_q);
  assign capture = armed_q && (cnt_q == STABLE_CNT);

  always_comb begin
    in_sel_d = selecters;
    in_led_d = LED;
    if (changed) begin
      cnt_d   = 4'd1;
      armed_d = 1'b1;
    end else begin
      cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      armed_d = armed_q && !capture;
    end
  end

  always_comb begin
    blank = 1'b0;
    legal = 1'b0;
    digit = 2'd0;
    case (in_sel_q)
      4'b1111: blank = 1'b1;
      4'b0111: begin legal = 1'b1; digit = 2'd3; end
      4'b1011: begin legal = 1'b1; digit = 2'd2; end
      4'b1101: begin legal = 1'b1; digit = 2'd1; end
      4'b1110: begin legal = 1'b1; digit = 2'd0; end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      EXP2:    exp_digit = 2'd2;
      EXP1:    exp_digit = 2'd1;
      EXP0:    exp_digit = 2'd0;
      default: exp_digit = 2'd3;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    sh3_d         = sh3_q;
    sh2_d         = sh2_q;
    sh1_d         = sh1_q;
    out3_d        = out3_q;
    out2_d        = out2_q;
    out1_d        = out1_q;
    out0_d        = out0_q;
    frame_valid_d = 1'b0;
    sel_error_d   = 1'b0;
    seq_error_d   = 1'b0;
    if (capture && !blank && !legal) begin
      sel_error_d = 1'b1;
      state_d     = IDLE;
      sh3_d       = 8'h00;
      sh2_d       = 8'h00;
      sh1_d       = 8'h00;
    end else if (capture && legal) begin
      if (state_q == IDLE) begin
        if (digit == 2'd3) begin
          sh3_d   = in_led_q;
          state_d = EXP2;
        end
      end else if (digit == exp_digit) begin
        case (state_q)
          EXP2: begin sh2_d = in_led_q; state_d = EXP1; end
          EXP1: begin sh1_d = in_led_q; state_d = EXP0; end
          default: begin
            out3_d        = sh3_q;
            out2_d        = sh2_q;
            out1_d        = sh1_q;
            out0_d        = in_led_q;
            frame_valid_d = 1'b1;
            state_d       = IDLE;
          end
        endcase
      end else if (digit == exp_digit + 2'd1) begin
        // Same strobe re-captured with a new pattern: refresh the digit just taken.
        case (digit)
          2'd3:    sh3_d = in_led_q;
          2'd2:    sh2_d = in_led_q;
          default: sh1_d = in_led_q;
        endcase
      end else begin
        seq_error_d = 1'b1;
        sh3_d       = 8'h00;
        sh2_d       = 8'h00;
        sh1_d       = 8'h00;
        if (digit == 2'd3) begin
          sh3_d   = in_led_q;
          state_d = EXP2;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      in_sel_q      <= 4'b1111;
      in_led_q      <= 8'h00;
      cnt_q         <= 4'd0;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      sh3_q         <= 8'h00;
      sh2_q         <= 8'h00;
      sh1_q         <= 8'h00;
      out3_q        <= 8'h00;
      out2_q        <= 8'h00;
      out1_q        <= 8'h00;
      out0_q        <= 8'h00;
      frame_valid_q <= 1'b0;
      sel_error_q   <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      in_sel_q      <= in_sel_d;
      in_led_q      <= in_led_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      sh3_q         <= sh3_d;
      sh2_q         <= sh2_d;
      sh1_q         <= sh1_d;
      out3_q        <= out3_d;
      out2_q        <= out2_d;
      out1_q        <= out1_d;
      out0_q        <= out0_d;
      frame_valid_q <= frame_valid_d;
      sel_error_q   <= sel_error_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign LED3        = out3_q;
  assign LED2        = out2_q;
  assign LED1        = out1_q;
  assign LED0        = out0_q;
  assign frame_valid = frame_valid_q;
  assign sel_error   = sel_error_q;
  assign seq_error   = seq_error_q;

`ifdef LED4_CAPTURE_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counts error cycles, not error kinds: both pulses together add one.
  always_comb begin
    err_count_d = err_count_q;
    if ((sel_error_q || seq_error_q) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) err_count_q <= 8'h00;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_led4_capture.sv
// Directed bench for led4_capture: one STABLE_CYCLES=1 instance and one STABLE_CYCLES=3 instance on a shared bus.
// Error-counter checks are compiled in when LED4_CAPTURE_ERRCNT_EN is defined.
module tb_led4_capture;

  logic       CK = 1'b0;
  logic       RST_N;
  logic [7:0] LED;
  logic [3:0] selecters;

  logic [7:0] a3, a2, a1, a0;
  logic       a_fv, a_sel, a_seq;
  logic [7:0] b3, b2, b1, b0;
  logic       b_fv, b_sel, b_seq;
`ifdef LED4_CAPTURE_ERRCNT_EN
  logic [7:0] a_err, b_err;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] patA [4] = '{8'h4F, 8'h5B, 8'h06, 8'h3F};
  logic [7:0] patB [4] = '{8'h07, 8'h7D, 8'h6D, 8'h66};
  logic [7:0] patC [4] = '{8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] patD [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  always #5 CK = ~CK;

  led4_capture #(.STABLE_CYCLES(1)) dut (
    .CK(CK), .RST_N(RST_N), .LED(LED), .selecters(selecters),
    .LED3(a3), .LED2(a2), .LED1(a1), .LED0(a0),
    .frame_valid(a_fv), .sel_error(a_sel), .seq_error(a_seq)
`ifdef LED4_CAPTURE_ERRCNT_EN
    , .err_count(a_err)
`endif
  );

  led4_capture #(.STABLE_CYCLES(3)) dut3 (
    .CK(CK), .RST_N(RST_N), .LED(LED), .selecters(selecters),
    .LED3(b3), .LED2(b2), .LED1(b1), .LED0(b0),
    .frame_valid(b_fv), .sel_error(b_sel), .seq_error(b_seq)
`ifdef LED4_CAPTURE_ERRCNT_EN
    , .err_count(b_err)
`endif
  );

  // Inputs change on the falling edge; checks made right after see the previous rising edge.
  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] led);
    @(negedge CK);
    selecters = sel;
    LED       = led;
  endtask

  // d >= 0 strobes that digit, -1 is blank, -2 is the illegal pattern 0011.
  task automatic driveStep(input int d, input logic [7:0] led);
    if (d >= 0)       applyStimulus(4'b1111 ^ (4'b0001 << d), led);
    else if (d == -1) applyStimulus(4'b1111, 8'h00);
    else              applyStimulus(4'b0011, 8'h55);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkPulses(input string tag, input int k,
                             input logic fv, input logic se, input logic qe,
                             input logic fv_e, input logic se_e, input logic qe_e);
    checkOutput($sformatf("%s fv k=%0d", tag, k),  {7'd0, fv}, {7'd0, fv_e});
    checkOutput($sformatf("%s sel k=%0d", tag, k), {7'd0, se}, {7'd0, se_e});
    checkOutput($sformatf("%s seq k=%0d", tag, k), {7'd0, qe}, {7'd0, qe_e});
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] o3, input logic [7:0] o2,
                            input logic [7:0] o1, input logic [7:0] o0,
                            input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    checkOutput({tag, " LED3"}, o3, e3);
    checkOutput({tag, " LED2"}, o2, e2);
    checkOutput({tag, " LED1"}, o1, e1);
    checkOutput({tag, " LED0"}, o0, e0);
  endtask

  initial begin
    int seq2 [8];
    int seq3 [5];
    int seq4 [7];
    int d;

    RST_N     = 1'b0;
    selecters = 4'b1111;
    LED       = 8'h00;
    repeat (2) @(negedge CK);
    $display("[TB] reset values");
    checkFrame("reset", a3, a2, a1, a0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkPulses("reset", 0, a_fv, a_sel, a_seq, 1'b0, 1'b0, 1'b0);
`ifdef LED4_CAPTURE_ERRCNT_EN
    checkOutput("reset err_count", a_err, 8'h00);
`endif
    RST_N = 1'b1;

    $display("[TB] nominal driver loop");
    for (int k = 0; k < 14; k++) begin
      if (k < 12) driveStep(3 - (k % 4), patA[3 - (k % 4)]);
      else        driveStep(-1, 8'h00);
      checkPulses("drv", k, a_fv, a_sel, a_seq, (k == 5) || (k == 9) || (k == 13), 1'b0, 1'b0);
    end
    checkFrame("drv", a3, a2, a1, a0, 8'h3F, 8'h06, 8'h5B, 8'h4F);

    $display("[TB] sync hunt from digit 1");
    seq2 = '{1, 0, 3, 2, 1, 0, -1, -1};
    for (int k = 0; k < 8; k++) begin
      d = seq2[k];
      driveStep(d, (d >= 0) ? patB[d] : 8'h00);
      checkPulses("hunt", k, a_fv, a_sel, a_seq, k == 7, 1'b0, 1'b0);
    end
    checkFrame("hunt", a3, a2, a1, a0, 8'h66, 8'h6D, 8'h7D, 8'h07);

    $display("[TB] out-of-order 3,2,0");
    seq3 = '{3, 2, 0, -1, -1};
    for (int k = 0; k < 5; k++) begin
      d = seq3[k];
      driveStep(d, (d >= 0) ? patC[d] : 8'h00);
      checkPulses("order", k, a_fv, a_sel, a_seq, 1'b0, 1'b0, k == 4);
    end
    checkFrame("order", a3, a2, a1, a0, 8'h66, 8'h6D, 8'h7D, 8'h07);

    $display("[TB] illegal strobe after digit 2");
    seq4 = '{3, 2, -2, 1, 0, -1, -1};
    for (int k = 0; k < 7; k++) begin
      d = seq4[k];
      driveStep(d, (d >= 0) ? patC[d] : 8'h00);
      checkPulses("illegal", k, a_fv, a_sel, a_seq, 1'b0, k == 4, 1'b0);
    end
    checkFrame("illegal", a3, a2, a1, a0, 8'h66, 8'h6D, 8'h7D, 8'h07);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) driveStep(3 - k, patC[3 - k]);
      else       driveStep(-1, 8'h00);
      checkPulses("recover", k, a_fv, a_sel, a_seq, k == 5, 1'b0, 1'b0);
    end
    checkFrame("recover", a3, a2, a1, a0, 8'h01, 8'h02, 8'h04, 8'h08);
`ifdef LED4_CAPTURE_ERRCNT_EN
    checkOutput("err_count after two errors", a_err, 8'h02);
`endif

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 5; k++) begin
      if (k < 3) driveStep(3 - k, patD[3 - k]);
      else       driveStep(-1, 8'h00);
    end
    #2 RST_N = 1'b0;
    #1;
    checkFrame("midreset", a3, a2, a1, a0, 8'h00, 8'h00, 8'h00, 8'h00);
    checkPulses("midreset", 0, a_fv, a_sel, a_seq, 1'b0, 1'b0, 1'b0);
`ifdef LED4_CAPTURE_ERRCNT_EN
    checkOutput("midreset err_count", a_err, 8'h00);
`endif
    @(negedge CK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) driveStep(0, patD[0]);
      else        driveStep(-1, 8'h00);
      checkPulses("postreset", k, a_fv, a_sel, a_seq, 1'b0, 1'b0, 1'b0);
    end
    checkFrame("postreset", a3, a2, a1, a0, 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] STABLE_CYCLES=3 two-cycle holds");
    for (int k = 0; k < 12; k++) begin
      if (k < 8) driveStep(3 - (k / 2), patA[3 - (k / 2)]);
      else       driveStep(-1, 8'h00);
      checkPulses("hold2", k, b_fv, b_sel, b_seq, 1'b0, 1'b0, 1'b0);
    end
    checkFrame("hold2", b3, b2, b1, b0, 8'h00, 8'h00, 8'h00, 8'h00);

    $display("[TB] STABLE_CYCLES=3 three-cycle holds");
    for (int k = 0; k < 16; k++) begin
      if (k < 12) driveStep(3 - (k / 3), patA[3 - (k / 3)]);
      else        driveStep(-1, 8'h00);
      checkPulses("hold3", k, b_fv, b_sel, b_seq, k == 13, 1'b0, 1'b0);
    end
    checkFrame("hold3", b3, b2, b1, b0, 8'h3F, 8'h06, 8'h5B, 8'h4F);

`ifdef LED4_CAPTURE_ERRCNT_EN
    $display("[TB] error counter saturation");
    checkOutput("err_count before streak", a_err, 8'h00);
    for (int k = 0; k < 300; k++)
      applyStimulus((k % 2 == 0) ? 4'b0011 : 4'b0000, 8'h00);
    repeat (3) driveStep(-1, 8'h00);
    checkOutput("err_count saturated", a_err, 8'hFF);
    for (int k = 0; k < 10; k++)
      applyStimulus((k % 2 == 0) ? 4'b0011 : 4'b0000, 8'h00);
    repeat (3) driveStep(-1, 8'h00);
    checkOutput("err_count held", a_err, 8'hFF);
    checkOutput("err_count slow instance", b_err, 8'h00);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("err_count after reset", a_err, 8'h00);
    @(negedge CK);
    RST_N = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led4_capture.md
# led4_capture

Receive-side counterpart of the 4-digit multiplexed 7-segment driver. Samples the strobed segment bus (`LED`, active-low `selecters`) and rebuilds the four digit patterns. Validates strobe legality and scan order, then publishes all four digits atomically with a one-cycle `frame_valid` pulse. Used as a display-capture/loopback monitor on the board and as the scoreboard front end in driver benches.

## Interface
- `STABLE_CYCLES`, default 1: consecutive identical samples required to accept a digit; legal 1..15.
- `CK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `LED`  in  8  segment bus.
- `selecters`  in  4  active-low digit strobes: 0111 = digit 3, 1011 = digit 2, 1101 = digit 1, 1110 = digit 0.
- `LED3`, `LED2`, `LED1`, `LED0`  out  8 each  captured digit patterns, updated only on frame completion.
- `frame_valid`  out  1  one-cycle pulse when a complete 3,2,1,0 frame has been published.
- `sel_error`  out  1  one-cycle pulse on an illegal strobe pattern.
- `seq_error`  out  1  one-cycle pulse on an out-of-order digit.
- `err_count`  out  8  present only with `LED4_CAPTURE_ERRCNT_EN`.

## Operation
- Input stage registers {`selecters`, `LED`} every edge. A 4-bit saturating counter tracks how long the pair has been unchanged.
- Any change in either field restarts the count and re-arms capture.
- A capture event fires once per armed dwell, when the pair has been present for `STABLE_CYCLES` sampling edges.
- `selecters` classification:
  - 1111 = blank. Ignored, no capture, no error.
  - One-hot-low = legal digit.
  - Anything else = illegal. Pulse `sel_error`, FSM goes to IDLE, shadow registers are discarded.
- FSM states: IDLE, EXP2, EXP1, EXP0.
  - IDLE: digit 3 capture loads shadow3 and goes to EXP2. Other digits are ignored silently (sync hunt).
  - EXPn: digit n capture loads shadown and advances. From EXP0, digit 0 goes to IDLE and publishes.
  - A re-capture of the digit just taken (same strobe, new `LED` value) overwrites that shadow. No state change, no error.
  - Any other digit: pulse `seq_error`, discard shadows. If that digit is 3, load shadow3 and go to EXP2; otherwise go to IDLE.
- Publish: `LED3`..`LED1` load from the shadows and `LED0` loads directly from the captured value on the same edge. `frame_valid` pulses.
- Outputs hold their previous frame until the next publish. Errors never modify the outputs.
- Simultaneous events: illegal strobe takes priority; no capture occurs that cycle.

## Timing
- A pair present at input edges k..k+STABLE_CYCLES-1 is captured at edge k+STABLE_CYCLES.
- Publish latency from the digit-0 input sample to `LED0`/`frame_valid`: STABLE_CYCLES edges.
- `frame_valid`, `sel_error` and `seq_error` are high for exactly one cycle, following the deciding edge.
- Nominal driver (1-cycle dwell, STABLE_CYCLES=1): one frame every 4 cycles.
- Reset values:
  - `LED3`..`LED0` = 8'h00.
  - Shadows = 8'h00.
  - All pulses = 0; `err_count` = 0.
  - FSM = IDLE.
  - Input register = {4'b1111, 8'h00}; count = 0.
- Reset mid-frame clears everything immediately, asynchronously. The partial frame is lost. The first post-reset frame requires a fresh digit 3.

## Configuration
- `LED4_CAPTURE_ERRCNT_EN` defined:
  - `err_count` port exists.
  - It increments by 1 on each cycle where `sel_error` or `seq_error` is high; both high in one cycle counts as 1.
  - It saturates at 255 and clears only on reset.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Driver loop, STABLE_CYCLES=1, patterns 3F/06/5B/4F on digits 3/2/1/0, digit 3 first at edge 1 -> first `frame_valid` after edge 5, then every 4 cycles. Outputs 3F,06,5B,4F. No errors.
- Stream starting at digit 1 (1101) -> no errors, no pulse until the first full 3..0 frame. Then the sequence 3,2,0 -> `seq_error` once, outputs unchanged.
- Illegal 4'b0011 injected after digit 2 -> one-cycle `sel_error`, no `frame_valid` for that frame, previous outputs held. The next clean frame publishes normally.
- STABLE_CYCLES=3: each digit held 2 cycles -> never captured. Held 3 cycles -> captured, and `frame_valid` follows the digit-0 capture edge.
- `RST_N` low between digit 1 and digit 0 -> outputs 00 immediately. The trailing digit 0 produces no `frame_valid` and no error.
- With `LED4_CAPTURE_ERRCNT_EN`: 300 illegal strobes -> `err_count` = 255 and stays there. Reset -> 0.
